// File: rtl/ark_pkg.sv
// Shared definitions for the ark_stream block: default geometry, FSM state
// encoding and the width helper used for index and counter sizing.
package ark_pkg;

   localparam int unsigned ARK_BLOCK_W  = 128;
   localparam int unsigned ARK_LANE_W   = 32;
   localparam int unsigned ARK_NUM_KEYS = 15;

   typedef enum logic [1:0] {
      ARK_IDLE = 2'd0,
      ARK_BUSY = 2'd1,
      ARK_DONE = 2'd2
   } ark_state_e;

   // clog2 clamped to at least one bit so degenerate sizes still give a legal vector
   function automatic int unsigned ark_width(input int unsigned n);
      int unsigned w;
      w = (n <= 1) ? 1 : $clog2(n);
      return w;
   endfunction

endpackage

// File: rtl/ark_stream_if.sv
// Bus bundle for ark_stream: key-bank write port, input block handshake and
// output result handshake. master drives blocks in, slave is the engine.
interface ark_stream_if
   import ark_pkg::*;
#(
   parameter int unsigned BLOCK_W = ARK_BLOCK_W,
   parameter int unsigned IDX_W   = ark_width(ARK_NUM_KEYS)
);

   logic               key_we;
   logic [IDX_W-1:0]   key_idx;
   logic [0:BLOCK_W-1] key_data;

   logic               in_valid;
   logic               in_ready;
   logic [0:BLOCK_W-1] in_data;
   logic [IDX_W-1:0]   in_round;

   logic               out_valid;
   logic               out_ready;
   logic [0:BLOCK_W-1] out_data;
   logic [IDX_W-1:0]   out_round;
   logic               out_err;

   modport master (
      output key_we, key_idx, key_data,
      output in_valid, in_data, in_round,
      output out_ready,
      input  in_ready,
      input  out_valid, out_data, out_round, out_err
   );

   modport slave (
      input  key_we, key_idx, key_data,
      input  in_valid, in_data, in_round,
      input  out_ready,
      output in_ready,
      output out_valid, out_data, out_round, out_err
   );

endinterface

// File: rtl/ark_key_bank.sv
// Round-key storage: NUM_KEYS entries of BLOCK_W bits, one synchronous write
// port and one combinational read port. Out-of-range writes are dropped and
// out-of-range reads return all-zero, which makes a bad round a pass-through.
module ark_key_bank
   import ark_pkg::*;
#(
   parameter int unsigned BLOCK_W  = ARK_BLOCK_W,
   parameter int unsigned NUM_KEYS = ARK_NUM_KEYS,
   parameter int unsigned IDX_W    = ark_width(ARK_NUM_KEYS)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               we,
   input  logic [IDX_W-1:0]   waddr,
   input  logic [0:BLOCK_W-1] wdata,
   input  logic [IDX_W-1:0]   raddr,
   output logic [0:BLOCK_W-1] rdata
);

   logic [0:BLOCK_W-1] mem_q [NUM_KEYS];
   logic [0:BLOCK_W-1] mem_d [NUM_KEYS];

   // Next bank contents: only an in-range address matches an entry
   always_comb begin
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
         mem_d[i] = mem_q[i];
         if (we && (waddr == IDX_W'(i))) begin
            mem_d[i] = wdata;
         end
      end
   end

   // Combinational read; unmatched (out-of-range) index yields zero
   always_comb begin
      rdata = '0;
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
         if (raddr == IDX_W'(i)) begin
            rdata = mem_q[i];
         end
      end
   end

   // Bank registers, cleared to zero on reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

endmodule

// File: rtl/ark_stream.sv
// ark_stream: XORs a BLOCK_W state block with a round key from a local bank,
// LANE_W bits per cycle, beat 0 covering the most-significant lane (bit 0).
// One block in flight; result is held until the consumer takes it.
module ark_stream
   import ark_pkg::*;
#(
   parameter int unsigned BLOCK_W  = ARK_BLOCK_W,
   parameter int unsigned LANE_W   = ARK_LANE_W,
   parameter int unsigned NUM_KEYS = ARK_NUM_KEYS
) (
   input  logic        clk,
   input  logic        rst,
   ark_stream_if.slave s
);

   localparam int unsigned IDX_W = ark_width(NUM_KEYS);
   localparam int unsigned BEATS = BLOCK_W / LANE_W;
   localparam int unsigned CNT_W = ark_width(BEATS + 1);

   localparam logic [IDX_W:0]   NK_LIMIT  = (IDX_W + 1)'(NUM_KEYS);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   if ((BLOCK_W % LANE_W) != 0) begin : g_bad_lane
      $error("ark_stream: BLOCK_W must be a whole multiple of LANE_W");
   end

   ark_state_e         state_q,     state_d;
   logic [CNT_W-1:0]   cnt_q,       cnt_d;
   logic [0:BLOCK_W-1] data_q,      data_d;
   logic [0:BLOCK_W-1] key_q,       key_d;
   logic [IDX_W-1:0]   round_q,     round_d;
   logic               err_q,       err_d;
   logic               in_ready_q,  in_ready_d;
   logic               out_valid_q, out_valid_d;

   logic [0:BLOCK_W-1] bank_rdata;
   logic [0:LANE_W-1]  lane_data;
   logic [0:LANE_W-1]  lane_key;
   logic [0:LANE_W-1]  lane_res;
   logic               accept;

   ark_key_bank #(
      .BLOCK_W  (BLOCK_W),
      .NUM_KEYS (NUM_KEYS),
      .IDX_W    (IDX_W)
   ) u_key_bank (
      .clk   (clk),
      .rst   (rst),
      .we    (s.key_we),
      .waddr (s.key_idx),
      .wdata (s.key_data),
      .raddr (s.in_round),
      .rdata (bank_rdata)
   );

   assign accept = s.in_valid & in_ready_q;

   // Steer the current beat's lane into a single LANE_W-wide XOR
   always_comb begin
      lane_data = '0;
      lane_key  = '0;
      for (int unsigned k = 0; k < BEATS; k++) begin
         if (cnt_q == CNT_W'(k)) begin
            lane_data = data_q[k*LANE_W +: LANE_W];
            lane_key  = key_q[k*LANE_W +: LANE_W];
         end
      end
      lane_res = lane_data ^ lane_key;
   end

   // FSM next-state and working-register updates
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      data_d      = data_q;
      key_d       = key_q;
      round_d     = round_q;
      err_d       = err_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;

      case (state_q)
         ARK_IDLE: begin
            if (accept) begin
               state_d    = ARK_BUSY;
               cnt_d      = '0;
               data_d     = s.in_data;
               key_d      = bank_rdata;
               round_d    = s.in_round;
               err_d      = ({1'b0, s.in_round} >= NK_LIMIT);
               in_ready_d = 1'b0;
            end
         end
         ARK_BUSY: begin
            for (int unsigned k = 0; k < BEATS; k++) begin
               if (cnt_q == CNT_W'(k)) begin
                  data_d[k*LANE_W +: LANE_W] = lane_res;
               end
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BEAT) begin
               state_d     = ARK_DONE;
               out_valid_d = 1'b1;
            end
         end
         ARK_DONE: begin
            if (s.out_ready) begin
               state_d     = ARK_IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
            end
         end
         default: begin
            state_d     = ARK_IDLE;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
         end
      endcase
   end

   // State and output registers; reset discards any block in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ARK_IDLE;
         cnt_q       <= '0;
         data_q      <= '0;
         key_q       <= '0;
         round_q     <= '0;
         err_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         data_q      <= data_d;
         key_q       <= key_d;
         round_q     <= round_d;
         err_q       <= err_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign s.in_ready  = in_ready_q;
   assign s.out_valid = out_valid_q;
   assign s.out_data  = data_q;
   assign s.out_round = round_q;
   assign s.out_err   = err_q;

endmodule

// File: tb/tb_ark_stream.sv
// Scoreboard bench for ark_stream: default build plus LANE_W=128 and
// LANE_W=8 instances checked against an XOR reference model.
module tb_ark_stream;
   import ark_pkg::*;

   localparam int unsigned BW = ARK_BLOCK_W;
   localparam int unsigned NK = 15;
   localparam int unsigned IW = ark_width(NK);
   localparam int TIMEOUT = 60;

   typedef logic [0:BW-1] blk_t;
   typedef logic [IW-1:0] idx_t;
   typedef struct packed {
      blk_t data;
      idx_t round;
      logic err;
   } res_t;

   logic clk = 1'b0;
   logic rst;
   int   vectors = 0;
   int   miscompares = 0;

   blk_t key_m [NK];
   blk_t key_x [NK];
   res_t q_main [$];
   res_t q_w [$];
   res_t q_n [$];

   always #5 clk = ~clk;

   ark_stream_if #(.BLOCK_W(BW), .IDX_W(IW)) bus  ();
   ark_stream_if #(.BLOCK_W(BW), .IDX_W(IW)) busw ();
   ark_stream_if #(.BLOCK_W(BW), .IDX_W(IW)) busn ();

   ark_stream #(.BLOCK_W(BW), .LANE_W(32),  .NUM_KEYS(NK)) dut   (.clk(clk), .rst(rst), .s(bus));
   ark_stream #(.BLOCK_W(BW), .LANE_W(128), .NUM_KEYS(NK)) dut_w (.clk(clk), .rst(rst), .s(busw));
   ark_stream #(.BLOCK_W(BW), .LANE_W(8),   .NUM_KEYS(NK)) dut_n (.clk(clk), .rst(rst), .s(busn));

   function automatic blk_t rand_blk();
      blk_t b;
      b = {$urandom(), $urandom(), $urandom(), $urandom()};
      return b;
   endfunction

   function automatic res_t model(blk_t d, idx_t r, blk_t k);
      res_t e;
      e.data  = d ^ k;
      e.round = r;
      e.err   = (int'(r) >= int'(NK));
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_models();
      for (int i = 0; i < int'(NK); i++) begin
         key_m[i] = '0;
         key_x[i] = '0;
      end
   endtask

   task automatic init_inputs();
      bus.key_we = 1'b0;  bus.key_idx = '0;  bus.key_data = '0;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.in_round = '0; bus.out_ready = 1'b0;
      busw.key_we = 1'b0; busw.key_idx = '0; busw.key_data = '0;
      busw.in_valid = 1'b0; busw.in_data = '0; busw.in_round = '0; busw.out_ready = 1'b0;
      busn.key_we = 1'b0; busn.key_idx = '0; busn.key_data = '0;
      busn.in_valid = 1'b0; busn.in_data = '0; busn.in_round = '0; busn.out_ready = 1'b0;
   endtask

   task automatic write_key(idx_t idx, blk_t k);
      bus.key_we = 1'b1; bus.key_idx = idx; bus.key_data = k;
      tick();
      bus.key_we = 1'b0;
      if (int'(idx) < int'(NK)) key_m[idx] = k;
   endtask

   task automatic write_key_x(idx_t idx, blk_t k);
      busw.key_we = 1'b1; busw.key_idx = idx; busw.key_data = k;
      busn.key_we = 1'b1; busn.key_idx = idx; busn.key_data = k;
      tick();
      busw.key_we = 1'b0; busn.key_we = 1'b0;
      if (int'(idx) < int'(NK)) key_x[idx] = k;
   endtask

   task automatic drive_main(blk_t d, idx_t r);
      bus.in_valid = 1'b1; bus.in_data = d; bus.in_round = r;
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic accept_main(blk_t d, idx_t r);
      blk_t k;
      k = (int'(r) < int'(NK)) ? key_m[r] : '0;
      q_main.push_back(model(d, r, k));
      drive_main(d, r);
   endtask

   // lat counts clock edges from the accept edge (inclusive) to out_valid
   task automatic wait_main(output res_t obs, output int lat);
      lat = 1;
      while (bus.out_valid !== 1'b1 && lat < TIMEOUT) begin
         tick();
         lat++;
      end
      obs = {bus.out_data, bus.out_round, bus.out_err};
   endtask

   task automatic release_main();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      vectors++;
      if ({bus.out_valid, bus.out_data, bus.out_round, bus.out_err} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got valid=%b data=%h round=%0d err=%b, want all zero",
                  bus.out_valid, bus.out_data, bus.out_round, bus.out_err);
      end
      rst = 1'b0;
      tick();
      vectors++;
      if ({bus.in_ready, busw.in_ready, busn.in_ready, bus.out_valid} !== 4'b1110) begin
         miscompares++;
         $display("FAIL reset_ready: got ready=%b%b%b valid=%b, want ready=111 valid=0",
                  bus.in_ready, busw.in_ready, busn.in_ready, bus.out_valid);
      end
      clear_models();
   endtask

   task automatic test_known_vector();
      res_t obs, e;
      int   lat;
      write_key(idx_t'(0), 128'h2b7e151628aed2a6abf7158809cf4f3c);
      q_main.push_back({128'h193de3bea0f4e22b9ac68d2ae9f84808, idx_t'(0), 1'b0});
      drive_main(128'h3243f6a8885a308d313198a2e0370734, idx_t'(0));
      wait_main(obs, lat);
      e = q_main.pop_front();
      vectors++;
      if (obs !== e) begin
         miscompares++;
         $display("FAIL known_vector: got %h want %h", obs, e);
      end
      vectors++;
      if (lat != 5) begin
         miscompares++;
         $display("FAIL known_latency: got %0d want 5", lat);
      end
      release_main();
      vectors++;
      if (bus.in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL known_release: in_ready got %b want 1", bus.in_ready);
      end
   endtask

   task automatic test_bad_round();
      res_t obs, e;
      int   lat;
      blk_t d1 = rand_blk();
      blk_t d2 = rand_blk();
      write_key(idx_t'(15), rand_blk());
      write_key(idx_t'(14), rand_blk());
      accept_main(d1, idx_t'(15));
      wait_main(obs, lat);
      e = q_main.pop_front();
      vectors++;
      if (obs !== e) begin
         miscompares++;
         $display("FAIL bad_round_passthru: got %h want %h", obs, e);
      end
      release_main();
      accept_main(d2, idx_t'(14));
      wait_main(obs, lat);
      e = q_main.pop_front();
      vectors++;
      if (obs !== e) begin
         miscompares++;
         $display("FAIL last_round_key: got %h want %h", obs, e);
      end
      release_main();
   endtask

   task automatic test_stall();
      res_t obs, e;
      int   lat;
      blk_t d = rand_blk();
      write_key(idx_t'(7), rand_blk());
      accept_main(d, idx_t'(7));
      wait_main(obs, lat);
      e = q_main.pop_front();
      vectors++;
      if (obs !== e) begin
         miscompares++;
         $display("FAIL stall_result: got %h want %h", obs, e);
      end
      bus.in_valid = 1'b1; bus.in_data = ~d; bus.in_round = idx_t'(0);
      for (int i = 0; i < 10; i++) begin
         tick();
         vectors++;
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
             {bus.out_data, bus.out_round, bus.out_err} !== e) begin
            miscompares++;
            $display("FAIL stall_hold: cycle %0d got valid=%b ready=%b res=%h want valid=1 ready=0 res=%h",
                     i, bus.out_valid, bus.in_ready, {bus.out_data, bus.out_round, bus.out_err}, e);
         end
      end
      bus.in_valid = 1'b0;
      release_main();
      vectors++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL stall_release: got ready=%b valid=%b want ready=1 valid=0", bus.in_ready, bus.out_valid);
      end
      tick();
      vectors++;
      if (bus.in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL stall_no_capture: in_ready got %b want 1", bus.in_ready);
      end
   endtask

   task automatic test_key_collision();
      res_t obs, e;
      int   lat;
      blk_t ka = rand_blk();
      blk_t kb = rand_blk();
      blk_t d1 = rand_blk();
      blk_t d2 = rand_blk();
      write_key(idx_t'(3), ka);
      q_main.push_back(model(d1, idx_t'(3), ka));
      bus.key_we = 1'b1; bus.key_idx = idx_t'(3); bus.key_data = kb;
      bus.in_valid = 1'b1; bus.in_data = d1; bus.in_round = idx_t'(3);
      tick();
      bus.key_we = 1'b0; bus.in_valid = 1'b0;
      key_m[3] = kb;
      wait_main(obs, lat);
      e = q_main.pop_front();
      vectors++;
      if (obs !== e) begin
         miscompares++;
         $display("FAIL collision_old_key: got %h want %h", obs, e);
      end
      release_main();
      accept_main(d2, idx_t'(3));
      wait_main(obs, lat);
      e = q_main.pop_front();
      vectors++;
      if (obs !== e) begin
         miscompares++;
         $display("FAIL collision_new_key: got %h want %h", obs, e);
      end
      release_main();
   endtask

   task automatic test_back_to_back();
      res_t obs, e;
      int   lat;
      for (int i = 0; i < int'(NK); i++) write_key(idx_t'(i), rand_blk());
      for (int i = 0; i < 6; i++) begin
         idx_t r;
         r = (i == 5) ? idx_t'(NK) : idx_t'($urandom_range(0, NK - 1));
         vectors++;
         if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_ready: block %0d in_ready got %b want 1", i, bus.in_ready);
         end
         accept_main(rand_blk(), r);
         wait_main(obs, lat);
         e = q_main.pop_front();
         vectors++;
         if (obs !== e || lat != 5) begin
            miscompares++;
            $display("FAIL b2b_result: block %0d got %h lat %0d want %h lat 5", i, obs, lat, e);
         end
         release_main();
      end
   endtask

   task automatic test_reset_midflight();
      res_t obs, e;
      int   lat;
      int   seen;
      write_key(idx_t'(2), rand_blk());
      accept_main(rand_blk(), idx_t'(2));
      tick();
      tick();
      #3;
      rst = 1'b1;
      #1;
      vectors++;
      if ({bus.out_valid, bus.out_data, bus.out_round, bus.out_err} !== '0 || bus.in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL midflight_reset_outputs: got valid=%b ready=%b data=%h round=%0d err=%b want 0/1/0/0/0",
                  bus.out_valid, bus.in_ready, bus.out_data, bus.out_round, bus.out_err);
      end
      tick();
      rst = 1'b0;
      q_main.delete();
      clear_models();
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.out_valid === 1'b1) seen++;
      end
      vectors++;
      if (seen != 0) begin
         miscompares++;
         $display("FAIL midflight_no_valid: out_valid seen %0d cycles want 0", seen);
      end
      accept_main(rand_blk(), idx_t'(2));
      wait_main(obs, lat);
      e = q_main.pop_front();
      vectors++;
      if (obs !== e) begin
         miscompares++;
         $display("FAIL midflight_bank_zero: got %h want %h", obs, e);
      end
      release_main();
   endtask

   task automatic test_lane_widths();
      res_t obs, e;
      for (int i = 0; i < int'(NK); i++) write_key_x(idx_t'(i), rand_blk());
      for (int b = 0; b < 8; b++) begin
         blk_t d;
         idx_t r;
         int   lw, ln;
         bit   dw, dn;
         d = rand_blk();
         r = idx_t'($urandom_range(0, 15));
         e = model(d, r, (int'(r) < int'(NK)) ? key_x[r] : '0);
         q_w.push_back(e);
         q_n.push_back(e);
         busw.in_valid = 1'b1; busw.in_data = d; busw.in_round = r;
         busn.in_valid = 1'b1; busn.in_data = d; busn.in_round = r;
         tick();
         busw.in_valid = 1'b0; busn.in_valid = 1'b0;
         lw = 1; ln = 1; dw = 1'b0; dn = 1'b0;
         for (int c = 0; c < TIMEOUT; c++) begin
            if (!dw && busw.out_valid === 1'b1) begin
               e = q_w.pop_front();
               obs = {busw.out_data, busw.out_round, busw.out_err};
               vectors++;
               if (obs !== e || lw != 2) begin
                  miscompares++;
                  $display("FAIL lane128: block %0d got %h lat %0d want %h lat 2", b, obs, lw, e);
               end
               dw = 1'b1;
               busw.out_ready = 1'b1;
            end
            if (!dn && busn.out_valid === 1'b1) begin
               e = q_n.pop_front();
               obs = {busn.out_data, busn.out_round, busn.out_err};
               vectors++;
               if (obs !== e || ln != 17) begin
                  miscompares++;
                  $display("FAIL lane8: block %0d got %h lat %0d want %h lat 17", b, obs, ln, e);
               end
               dn = 1'b1;
               busn.out_ready = 1'b1;
            end
            if (dw && dn) break;
            tick();
            if (!dw) lw++;
            if (!dn) ln++;
         end
         if (!dw) begin
            vectors++; miscompares++;
            void'(q_w.pop_front());
            $display("FAIL lane128_timeout: block %0d no out_valid within %0d cycles", b, TIMEOUT);
         end
         if (!dn) begin
            vectors++; miscompares++;
            void'(q_n.pop_front());
            $display("FAIL lane8_timeout: block %0d no out_valid within %0d cycles", b, TIMEOUT);
         end
         tick();
         busw.out_ready = 1'b0; busn.out_ready = 1'b0;
      end
   endtask

   initial begin
      init_inputs();
      clear_models();
      test_reset();
      test_known_vector();
      test_bad_round();
      test_stall();
      test_key_collision();
      test_back_to_back();
      test_reset_midflight();
      test_lane_widths();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
